rng_stimulus_scheduler: RTL
===========================

// Module: rng_stimulus_scheduler
// PURPOSE
//  Replaces the bank of independent random number generators in the *_random wrappers
//  with one shared Galois LFSR. Time-multiplexes it between NUM_CH requesters under
//  round-robin arbitration. Sits between clk/reset and the pseudo-random DUT inputs
//  (sram data, x/y, bus words). Seedable, start/stop controllable; keeps stimulus
//  deterministic across builds.
// PARAMETERS
//  NUM_CH      8              number of requesting channels (2..16)
//  CH_WIDTH    16             width of each delivered word; must be <= LFSR_WIDTH
//  LFSR_WIDTH  32             LFSR state width
//  TAPS        32'h8020_0003  right-shift Galois mask (x^32+x^22+x^2+x+1)
//  SEED        32'hACE1_1234  reset seed; also replaces any zero seed load
// PORTS
//  clk             in   1                   single clock
//  reset           in   1                   synchronous, active-high
//  start           in   1                   pulse: IDLE -> RUN
//  stop            in   1                   pulse: RUN -> IDLE
//  free_run        in   1                   RUN: treat every ch_req bit as 1
//  seed_valid      in   1                   seed load request
//  seed_data       in   LFSR_WIDTH          seed value
//  seed_ready      out  1                   1 only in IDLE
//  ch_req          in   NUM_CH              per-channel request for a fresh word
//  ch_valid        out  NUM_CH              one-hot, 1-cycle pulse: ch_data[i] updated
//  ch_data         out  NUM_CH x CH_WIDTH   last word delivered per channel (held)
//  busy            out  1                   1 in RUN
//  word_count      out  32                  grants since reset, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (sync, wins over all inputs): state=IDLE, lfsr=SEED, ch_data=0, ch_valid=0,
//   rr_ptr=0, word_count=0, busy=0, seed_ready=1. Reset mid-RUN drops any in-flight grant.
//  States:
//   - IDLE: lfsr and ch_data hold. seed_valid&seed_ready -> lfsr<=(seed_data==0)?SEED:seed_data
//     at that edge. start -> RUN. If seed and start arrive together, load the seed, then
//     RUN from the new seed.
//   - RUN: stop -> IDLE. stop has priority over start. The cycle in which stop is seen
//     still performs its grant.
//  Arbitration (RUN only): eff_req = free_run ? '1 : ch_req.
//   - g = first set bit of eff_req scanning rr_ptr, rr_ptr+1, ... mod NUM_CH.
//   - Latency 1: request seen at edge t. At t+1: ch_data[g] = lfsr[CH_WIDTH-1:0]
//     (pre-advance value), ch_valid = 1<<g, lfsr advances one step,
//     rr_ptr = (g+1) mod NUM_CH, word_count += 1 (saturating).
//   - No request -> no grant; lfsr, rr_ptr and word_count hold; ch_valid=0.
//   - At most one grant per cycle. A channel holding ch_req high gets a word every cycle
//     only if it is the sole requester. Otherwise it is served once per rotation.
//  LFSR step: next = lfsr[0] ? (lfsr>>1)^TAPS : lfsr>>1. The LFSR never holds 0.
//  ch_req bits are ignored in IDLE. No grant on the start cycle itself; first grant is
//   on the cycle after RUN is entered.
// STRUCTURE
//  Shared package rng_sched_pkg:
//   - typedef enum logic {IDLE,RUN} sched_state_t
//   - default TAPS/SEED localparams
//   - function lfsr_next(state, taps)
//  One sub-module rr_arbiter #(N): inputs req, ptr; outputs gnt_onehot, gnt_idx, any.
//   Purely combinational. The ptr register lives in the parent.
// TESTING
//  1 Reset: assert reset 2 cycles mid-RUN -> ch_data all 0, ch_valid 0, word_count 0,
//    busy 0, seed_ready 1.
//  2 Seed/LFSR: IDLE, seed_data=32'h1, then start, ch_req=8'h01 held ->
//    ch_data[0] sequence 16'h0001, 16'h0003 (lfsr 32'h0000_0001 -> 32'h8020_0003).
//  3 Zero seed: load 0 then request -> first word is 16'h1234 (SEED substituted).
//  4 Round robin: ch_req=8'hA5 held, rr_ptr=0 -> grant order 0,2,5,7,0,...;
//    ch_valid one-hot every cycle.
//  5 Start/stop: stop and start same cycle in RUN -> IDLE; later ch_req ignored,
//    word_count frozen, seed_ready=1.
//  6 free_run=1, ch_req=0, 16 cycles -> each channel updated exactly twice,
//    word_count=16.

Source files
------------

// File: rtl/rng_sched_pkg.sv
// ----------------------------------------------------------------------------
// rng_sched_pkg
// Shared types, default constants and the LFSR step function for the
// rng_stimulus_scheduler block.
//   sched_state_t : scheduler mode (IDLE / RUN)
//   DEFAULT_TAPS  : right-shift Galois mask for x^32+x^22+x^2+x+1
//   DEFAULT_SEED  : reset seed, also substituted for any zero seed load
//   lfsr_next()   : one right-shift Galois step on a zero-extended state
// ----------------------------------------------------------------------------
package rng_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_1234;

  // Widest LFSR the step function supports; narrower states are zero-extended.
  localparam int LFSR_MAX_W = 64;

  // Right-shift Galois step. Zero-extension is harmless: the upper bits of a
  // narrower state and its taps stay zero through the shift and XOR.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    logic [LFSR_MAX_W-1:0] shifted;
    shifted = state >> 1;
    if (state[0]) begin
      lfsr_next = shifted ^ taps;
    end else begin
      lfsr_next = shifted;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set bit of req, scanning
// ptr, ptr+1, ... modulo N. The pointer register is owned by the parent.
//   req        in  N      request vector
//   ptr        in  IW     scan start position
//   gnt_onehot out N      one-hot grant (all zero when no request)
//   gnt_idx    out IW     index of the granted bit (0 when no request)
//   any        out 1      at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;

  // Rotate the request vector so bit k of rot_s is request (ptr+k) mod N.
  assign dbl_s = {req, req} >> ptr;
  assign rot_s = dbl_s[N-1:0];

  // First set bit of the rotated vector, mapped back to an absolute index.
  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!any && rot_s[k]) begin
        any     = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % N);
      end else begin
        any     = any;
      end
    end
  end

  // Expand the chosen index to a one-hot vector.
  always_comb begin
    if (any) begin
      gnt_onehot = N'(1'b1) << gnt_idx;
    end else begin
      gnt_onehot = '0;
    end
  end

endmodule

// File: rtl/rng_stimulus_scheduler.sv
// ----------------------------------------------------------------------------
// rng_stimulus_scheduler
// One shared Galois LFSR time-multiplexed between NUM_CH requesters with
// round-robin arbitration. Seedable in IDLE; grants only in RUN.
//   clk, reset      clock and synchronous active-high reset
//   start / stop    pulses moving IDLE->RUN / RUN->IDLE (stop wins)
//   free_run        in RUN every channel is treated as requesting
//   seed_valid/data seed load, accepted only while seed_ready (IDLE)
//   ch_req          per-channel request for a fresh word
//   ch_valid        one-hot pulse marking the channel updated this cycle
//   ch_data         last word delivered to each channel (held)
//   busy            high in RUN
//   word_count      saturating count of grants since reset
// ----------------------------------------------------------------------------
module rng_stimulus_scheduler
  import rng_sched_pkg::*;
#(
  parameter int                    NUM_CH     = 8,
  parameter int                    CH_WIDTH   = 16,
  parameter int                    LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = LFSR_WIDTH'(DEFAULT_TAPS),
  parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(DEFAULT_SEED)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             free_run,
  input  logic                             seed_valid,
  input  logic [LFSR_WIDTH-1:0]            seed_data,
  output logic                             seed_ready,
  input  logic [NUM_CH-1:0]                ch_req,
  output logic [NUM_CH-1:0]                ch_valid,
  output logic [NUM_CH-1:0][CH_WIDTH-1:0]  ch_data,
  output logic                             busy,
  output logic [31:0]                      word_count
);

  localparam int PW = $clog2(NUM_CH);

  sched_state_t                     state_q, state_d;
  logic [LFSR_WIDTH-1:0]            lfsr_q, lfsr_d;
  logic [NUM_CH-1:0][CH_WIDTH-1:0]  ch_data_q, ch_data_d;
  logic [NUM_CH-1:0]                ch_valid_q, ch_valid_d;
  logic [PW-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [31:0]                      word_count_q, word_count_d;

  logic [NUM_CH-1:0]                arb_req_s;
  logic [NUM_CH-1:0]                gnt_onehot_s;
  logic [PW-1:0]                    gnt_idx_s;
  logic                             gnt_any_s;
  logic [LFSR_WIDTH-1:0]            lfsr_step_s;

  // Requests are only presented to the arbiter in RUN, so IDLE never grants.
  always_comb begin
    if (state_q == RUN) begin
      arb_req_s = free_run ? {NUM_CH{1'b1}} : ch_req;
    end else begin
      arb_req_s = '0;
    end
  end

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (PW)
  ) u_arb (
    .req        (arb_req_s),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .any        (gnt_any_s)
  );

  assign lfsr_step_s = LFSR_WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(TAPS)));

  // Next-state logic: seeding and start in IDLE, grants and stop in RUN.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    ch_data_d    = ch_data_q;
    ch_valid_d   = '0;
    rr_ptr_d     = rr_ptr_q;
    word_count_d = word_count_q;
    case (state_q)
      IDLE: begin
        // A zero seed would lock the LFSR, so it is replaced by SEED.
        if (seed_valid) begin
          lfsr_d = (seed_data == '0) ? SEED : seed_data;
        end else begin
          lfsr_d = lfsr_q;
        end
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The word handed out is the pre-advance LFSR value.
        if (gnt_any_s) begin
          ch_data_d[gnt_idx_s] = lfsr_q[CH_WIDTH-1:0];
          ch_valid_d           = gnt_onehot_s;
          lfsr_d               = lfsr_step_s;
          if (gnt_idx_s == PW'(NUM_CH - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = gnt_idx_s + PW'(1);
          end
          if (word_count_q == 32'hFFFF_FFFF) begin
            word_count_d = word_count_q;
          end else begin
            word_count_d = word_count_q + 32'd1;
          end
        end else begin
          ch_valid_d = '0;
        end
        // stop still lets this cycle's grant complete; start is ignored here.
        if (stop) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      rr_ptr_q     <= '0;
      word_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      word_count_q <= word_count_d;
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign word_count = word_count_q;
  assign busy       = (state_q == RUN);
  assign seed_ready = (state_q == IDLE);

endmodule
